// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer placed directly upstream of the
// 32-bit PC register. It steers the PC register (pc_next / pc_write_n),
// issues fetches to instruction memory, and holds one fetched instruction
// for decode. Taken branches redirect the PC.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            synchronous active-high reset
//   pc_q           current PC, read back from the PC register
//   pc_next        value for the PC register input
//   pc_write_n     active-low PC write strobe
//   imem_req       fetch request
//   imem_addr      fetch address
//   imem_ack       memory returns data this cycle
//   imem_rdata     instruction word, valid with imem_ack
//   branch_taken   single-cycle redirect request
//   branch_target  redirect address (low two bits ignored)
//   inst_valid     held instruction is available
//   inst_ready     decode accepts the held instruction
//   inst           held instruction word
//   inst_pc        address of the held instruction
//
// pc_next, pc_write_n, imem_req and imem_addr are combinational so the PC
// register samples them on the same edge as this block's state change.

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_next,
    output logic        pc_write_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        capture_s;
    logic [31:0] target_aligned_s;

    // Redirect address with the byte-offset bits forced to zero.
    assign target_aligned_s = branch_target & 32'hFFFF_FFFC;

    // Next-state and combinational PC/memory controls from state and inputs.
    always_comb begin
        state_next_s = state_r;
        pc_next      = pc_q;
        pc_write_n   = 1'b1;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        capture_s    = 1'b0;
        case (state_r)
            BOOT: begin
                // Re-initialise the PC; branches are ignored here.
                pc_next      = RESET_PC;
                pc_write_n   = 1'b0;
                state_next_s = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    // Redirect wins over a same-cycle ack; data is dropped.
                    pc_next      = target_aligned_s;
                    pc_write_n   = 1'b0;
                    state_next_s = REQ;
                end else if (imem_ack) begin
                    capture_s    = 1'b1;
                    pc_next      = pc_q + 32'd4;
                    pc_write_n   = 1'b0;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = REQ;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    // Held instruction is dropped even if decode accepts it.
                    pc_next      = target_aligned_s;
                    pc_write_n   = 1'b0;
                    state_next_s = REQ;
                end else if (inst_ready) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = BOOT;
            end
        endcase
    end

    // State register and held instruction/address capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= BOOT;
            inst_r    <= 32'h0000_0000;
            inst_pc_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if (capture_s) begin
                inst_r    <= imem_rdata;
                inst_pc_r <= pc_q;
            end
        end
    end

    assign inst_valid = (state_r == HOLD);
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

endmodule
